// File: rtl/tetromino_bag_queue.sv
//------------------------------------------------------------------------------
// Module      : tetromino_bag_queue
// Description : 7-bag tetromino randomizer feeding an in-order spawn/preview
//               queue. One draw decision per cycle with a bounded-retry
//               fallback to the lowest remaining piece.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tetromino_bag_queue #(
    parameter int width_p     = 32,
    parameter int depth_p     = 4,
    parameter int max_tries_p = 4
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic [width_p-1:0]             random_i,
    input  logic                           yumi_i,
    output logic                           valid_o,
    output logic [2:0]                     piece_o,
    output logic [3*depth_p-1:0]           queue_o,
    output logic [$clog2(depth_p+1)-1:0]   count_o,
    output logic [6:0]                     bag_o
);

    localparam int c_cnt_w = $clog2(depth_p + 1);
    localparam int c_try_w = (max_tries_p > 1) ? $clog2(max_tries_p) : 1;

    logic [2:0]         r_slot [depth_p];
    logic [c_cnt_w-1:0] r_count;
    logic [6:0]         r_bag;
    logic [c_try_w-1:0] r_try;

    logic [2:0]         w_cand;
    logic [7:0]         w_bag_ext;
    logic               w_pop;
    logic               w_active;
    logic               w_accept;
    logic               w_fallback;
    logic               w_draw;
    logic [2:0]         w_lowest;
    logic [2:0]         w_id;
    logic [6:0]         w_bag_clr;
    logic [6:0]         w_bag_next;
    logic [c_try_w-1:0] w_try_next;
    logic [c_cnt_w-1:0] w_count_next;
    logic [c_cnt_w-1:0] w_push_idx;
    logic [2:0]         w_shifted   [depth_p];
    logic [2:0]         w_slot_next [depth_p];

    // Only the low three bits of the random word are consumed.
    generate
        if (width_p > 3) begin : g_unused
            logic w_unused_bits;
            assign w_unused_bits = ^random_i[width_p-1:3];
        end
    endgenerate

    always_comb begin
        w_cand     = random_i[2:0];
        w_bag_ext  = {1'b0, r_bag};
        w_pop      = yumi_i && (r_count != '0);
        w_active   = (r_count < c_cnt_w'(depth_p)) || yumi_i;
        w_accept   = w_bag_ext[w_cand];
        w_fallback = !w_accept && (r_try == c_try_w'(max_tries_p - 1));
        w_draw     = w_active && (w_accept || w_fallback);

        w_lowest = 3'd0;
        for (int n = 6; n >= 0; n--) begin
            if (r_bag[n]) begin
                w_lowest = 3'(n);
            end
        end

        w_id      = w_accept ? w_cand : w_lowest;
        w_bag_clr = r_bag & ~(7'd1 << w_id);
        // An emptied bag reloads on the same edge so no cycle sees it empty.
        if (w_draw) begin
            w_bag_next = (w_bag_clr == 7'd0) ? 7'h7F : w_bag_clr;
        end else begin
            w_bag_next = r_bag;
        end

        if (!w_active) begin
            w_try_next = r_try;
        end else if (w_draw) begin
            w_try_next = '0;
        end else begin
            w_try_next = r_try + c_try_w'(1);
        end

        w_count_next = r_count;
        if (w_pop && !w_draw) begin
            w_count_next = r_count - c_cnt_w'(1);
        end else if (w_draw && !w_pop) begin
            w_count_next = r_count + c_cnt_w'(1);
        end

        w_push_idx = w_pop ? (r_count - c_cnt_w'(1)) : r_count;

        for (int k = 0; k < depth_p - 1; k++) begin
            w_shifted[k] = r_slot[k+1];
        end
        w_shifted[depth_p-1] = r_slot[depth_p-1];

        for (int k = 0; k < depth_p; k++) begin
            w_slot_next[k] = w_pop ? w_shifted[k] : r_slot[k];
            if (w_draw && (w_push_idx == c_cnt_w'(k))) begin
                w_slot_next[k] = w_id;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_count <= '0;
            r_bag   <= 7'h7F;
            r_try   <= '0;
            for (int k = 0; k < depth_p; k++) begin
                r_slot[k] <= 3'd0;
            end
        end else begin
            r_count <= w_count_next;
            r_bag   <= w_bag_next;
            r_try   <= w_try_next;
            for (int k = 0; k < depth_p; k++) begin
                r_slot[k] <= w_slot_next[k];
            end
        end
    end

    generate
        for (genvar k = 0; k < depth_p; k++) begin : g_slot
            assign queue_o[3*k +: 3] = r_slot[k];
        end
    endgenerate

    assign valid_o = (r_count != '0);
    assign piece_o = r_slot[0];
    assign count_o = r_count;
    assign bag_o   = r_bag;

endmodule

`default_nettype wire

// File: tb/tb_tetromino_bag_queue.sv
//------------------------------------------------------------------------------
// Module      : tb_tetromino_bag_queue
// Description : Directed and model-checked bench for tetromino_bag_queue.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_tetromino_bag_queue;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic [31:0] random_i;
    logic        yumi_i;
    logic        valid_o;
    logic [2:0]  piece_o;
    logic [11:0] queue_o;
    logic [2:0]  count_o;
    logic [6:0]  bag_o;

    int total = 0;
    int bad   = 0;

    tetromino_bag_queue #(.width_p(32), .depth_p(4), .max_tries_p(4)) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .random_i  (random_i),
        .yumi_i    (yumi_i),
        .valid_o   (valid_o),
        .piece_o   (piece_o),
        .queue_o   (queue_o),
        .count_o   (count_o),
        .bag_o     (bag_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset;
        reset_n_i = 1'b0;
        yumi_i    = 1'b0;
        random_i  = 32'd0;
        repeat (2) tick;
        reset_n_i = 1'b1;
    endtask

    task automatic test_reset;
        reset_n_i = 1'b0;
        yumi_i    = 1'b0;
        random_i  = 32'd0;
        repeat (2) tick;
        total++;
        if ({count_o, valid_o, piece_o, queue_o, bag_o} !== {3'd0, 1'b0, 3'd0, 12'h000, 7'h7F}) begin
            bad++;
            $display("FAIL reset_state: cnt=%0d vld=%0b pc=%0d q=%h bag=%h required 0 0 0 000 7f",
                     count_o, valid_o, piece_o, queue_o, bag_o);
        end
        reset_n_i = 1'b1;
        random_i  = 32'd7;
        yumi_i    = 1'b1;
        tick;
        yumi_i = 1'b0;
        total++;
        if (count_o !== 3'd0 || valid_o !== 1'b0) begin
            bad++;
            $display("FAIL yumi_when_empty: cnt=%0d vld=%0b required 0 0", count_o, valid_o);
        end
    endtask

    task automatic test_hold_zero;
        do_reset;
        random_i = 32'd0;
        repeat (12) tick;
        total++;
        if (count_o !== 3'd3) begin
            bad++;
            $display("FAIL zero_count12: got %0d required 3", count_o);
        end
        tick;
        total++;
        if (count_o !== 3'd4 || queue_o !== 12'h688 || bag_o !== 7'h70) begin
            bad++;
            $display("FAIL zero_fill: cnt=%0d q=%h bag=%h required 4 688 70", count_o, queue_o, bag_o);
        end
        repeat (8) tick;
        total++;
        if (count_o !== 3'd4 || queue_o !== 12'h688 || bag_o !== 7'h70) begin
            bad++;
            $display("FAIL zero_stall: cnt=%0d q=%h bag=%h required 4 688 70", count_o, queue_o, bag_o);
        end
    endtask

    task automatic test_hold_seven;
        int n;
        do_reset;
        random_i = 32'd7;
        repeat (15) tick;
        total++;
        if (count_o !== 3'd3) begin
            bad++;
            $display("FAIL seven_count15: got %0d required 3", count_o);
        end
        tick;
        total++;
        if (count_o !== 3'd4 || queue_o !== 12'h688 || bag_o !== 7'h70) begin
            bad++;
            $display("FAIL seven_fill: cnt=%0d q=%h bag=%h required 4 688 70", count_o, queue_o, bag_o);
        end
        for (int p = 0; p < 4; p++) begin
            total++;
            if (piece_o !== 3'(p)) begin
                bad++;
                $display("FAIL seven_head: got %0d required %0d", piece_o, p);
            end
            yumi_i = 1'b1;
            tick;
            yumi_i = 1'b0;
            n = 0;
            while (count_o != 3'd4 && n < 10) begin
                tick;
                n++;
            end
            total++;
            if (n != 3 || queue_o[11:9] !== 3'((p + 4) % 7)) begin
                bad++;
                $display("FAIL seven_refill: wait=%0d slot3=%0d required 3 %0d", n, queue_o[11:9], (p + 4) % 7);
            end
            if (p == 2) begin
                total++;
                if (bag_o !== 7'h7F) begin
                    bad++;
                    $display("FAIL seven_reload: bag=%h required 7f", bag_o);
                end
            end
        end
        total++;
        if (bag_o !== 7'h7E || queue_o !== 12'h1AC) begin
            bad++;
            $display("FAIL seven_newbag: bag=%h q=%h required 7e 1ac", bag_o, queue_o);
        end
    endtask

    task automatic test_in_order;
        do_reset;
        for (int i = 0; i < 4; i++) begin
            random_i = 32'(i);
            tick;
        end
        total++;
        if (count_o !== 3'd4 || queue_o !== 12'h688) begin
            bad++;
            $display("FAIL order_fill: cnt=%0d q=%h required 4 688", count_o, queue_o);
        end
        for (int i = 4; i < 21; i++) begin
            random_i = 32'(i % 7);
            yumi_i   = 1'b1;
            total++;
            if (piece_o !== 3'((i - 4) % 7)) begin
                bad++;
                $display("FAIL order_head: step=%0d got %0d required %0d", i, piece_o, (i - 4) % 7);
            end
            tick;
            total++;
            if (count_o !== 3'd4) begin
                bad++;
                $display("FAIL order_count: step=%0d got %0d required 4", i, count_o);
            end
        end
        yumi_i = 1'b0;
    endtask

    task automatic test_full_push_pop;
        do_reset;
        for (int i = 0; i < 4; i++) begin
            random_i = 32'(i);
            tick;
        end
        random_i = 32'd5;
        yumi_i   = 1'b1;
        tick;
        yumi_i = 1'b0;
        total++;
        if (count_o !== 3'd4 || queue_o !== 12'hAD1 || bag_o !== 7'h50) begin
            bad++;
            $display("FAIL full_pushpop: cnt=%0d q=%h bag=%h required 4 ad1 50", count_o, queue_o, bag_o);
        end
        random_i = 32'd0;
        repeat (10) tick;
        total++;
        if (count_o !== 3'd4 || queue_o !== 12'hAD1 || bag_o !== 7'h50) begin
            bad++;
            $display("FAIL full_frozen: cnt=%0d q=%h bag=%h required 4 ad1 50", count_o, queue_o, bag_o);
        end
        yumi_i = 1'b1;
        tick;
        yumi_i = 1'b0;
        repeat (2) tick;
        total++;
        if (count_o !== 3'd3 || piece_o !== 3'd2) begin
            bad++;
            $display("FAIL try_held: cnt=%0d pc=%0d required 3 2", count_o, piece_o);
        end
        tick;
        total++;
        if (count_o !== 3'd4 || queue_o !== 12'h95A || bag_o !== 7'h40) begin
            bad++;
            $display("FAIL try_fallback: cnt=%0d q=%h bag=%h required 4 95a 40", count_o, queue_o, bag_o);
        end
    endtask

    task automatic test_async_reset;
        do_reset;
        random_i = 32'd6;
        tick;
        random_i = 32'd0;
        tick;
        random_i = 32'd1;
        yumi_i   = 1'b1;
        tick;
        yumi_i   = 1'b0;
        random_i = 32'd7;
        total++;
        if (count_o !== 3'd2 || bag_o !== 7'h3C || queue_o[5:0] !== 6'b001000) begin
            bad++;
            $display("FAIL midfill: cnt=%0d bag=%h q=%h required 2 3c ..08", count_o, bag_o, queue_o);
        end
        #2 reset_n_i = 1'b0;
        #1;
        total++;
        if ({count_o, valid_o, piece_o, queue_o, bag_o} !== {3'd0, 1'b0, 3'd0, 12'h000, 7'h7F}) begin
            bad++;
            $display("FAIL async_reset: cnt=%0d vld=%0b pc=%0d q=%h bag=%h required 0 0 0 000 7f",
                     count_o, valid_o, piece_o, queue_o, bag_o);
        end
        tick;
        reset_n_i = 1'b1;
        random_i  = 32'd3;
        tick;
        total++;
        if (count_o !== 3'd1 || piece_o !== 3'd3 || bag_o !== 7'h77) begin
            bad++;
            $display("FAIL restart: cnt=%0d pc=%0d bag=%h required 1 3 77", count_o, piece_o, bag_o);
        end
    endtask

    task automatic test_random;
        int         mq[$];
        logic [6:0] mbag;
        int         mtry;
        int         draws;
        int         cycles;
        int         popped;
        logic [6:0] seen;
        int         cand;
        int         id;
        bit         act;
        do_reset;
        mbag   = 7'h7F;
        mtry   = 0;
        draws  = 0;
        cycles = 0;
        popped = 0;
        seen   = 7'h00;
        while (draws < 7000 && cycles < 40000) begin
            random_i = $urandom;
            yumi_i   = valid_o && ($urandom_range(0, 3) != 0);
            cand = int'(random_i[2:0]);
            act  = (mq.size() < 4) || yumi_i;
            id   = -1;
            if (act) begin
                if (cand < 7 && mbag[cand]) begin
                    id = cand;
                end else if (mtry == 3) begin
                    for (int n = 0; n < 7; n++) begin
                        if (mbag[n] && id < 0) id = n;
                    end
                end else begin
                    mtry++;
                end
            end
            if (id >= 0) begin
                mtry     = 0;
                mbag[id] = 1'b0;
                if (mbag == 7'h00) mbag = 7'h7F;
                draws++;
            end
            if (yumi_i && mq.size() > 0) begin
                total++;
                if (piece_o > 3'd6 || seen[piece_o]) begin
                    bad++;
                    $display("FAIL bag_window: pop=%0d piece=%0d seen=%b", popped, piece_o, seen);
                end
                if (piece_o <= 3'd6) seen[piece_o] = 1'b1;
                popped++;
                if (popped % 7 == 0) seen = 7'h00;
                void'(mq.pop_front());
            end
            if (id >= 0) mq.push_back(id);
            tick;
            cycles++;
            total++;
            if (count_o !== 3'(mq.size()) || bag_o !== mbag ||
                (mq.size() > 0 && piece_o !== 3'(mq[0]))) begin
                bad++;
                $display("FAIL model: cyc=%0d cnt=%0d bag=%h pc=%0d required %0d %h %0d",
                         cycles, count_o, bag_o, piece_o, mq.size(), mbag,
                         (mq.size() > 0) ? mq[0] : 0);
            end
        end
        yumi_i = 1'b0;
        total++;
        if (draws < 7000) begin
            bad++;
            $display("FAIL random_budget: draws=%0d required 7000", draws);
        end
    endtask

    initial begin
        reset_n_i = 1'b0;
        yumi_i    = 1'b0;
        random_i  = 32'd0;
        test_reset;
        test_hold_zero;
        test_hold_seven;
        test_in_order;
        test_full_push_pop;
        test_async_reset;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
